// File: rtl/datamem_bank_if.sv
// Request/response bundle for datamem_bank: one request per cycle in,
// registered read data plus valid/ready status out.
interface datamem_bank_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
);
  logic                en_DM;
  logic                we_DM;
  logic [DATA_W/8-1:0] be_DM;
  logic [DATA_W-1:0]   dataDM;
  logic [ADDR_W-1:0]   addDM;
  logic [DATA_W-1:0]   outDM;
  logic                valid_DM;
  logic                ready_DM;

  modport master (
    output en_DM, we_DM, be_DM, dataDM, addDM,
    input  outDM, valid_DM, ready_DM
  );

  modport slave (
    input  en_DM, we_DM, be_DM, dataDM, addDM,
    output outDM, valid_DM, ready_DM
  );
endinterface

// File: rtl/datamem_bank.sv
// Single-port data memory bank with byte-enable writes, registered reads and
// an optional zero-fill sweep that runs after every reset.
//
// state | meaning
// CLEAR | sweep writes 0 to clrCnt each cycle, requests dropped
// IDLE  | requests accepted, one per cycle
module datamem_bank #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 12,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic clk,
  input logic rst,
  datamem_bank_if.slave bus
);
  localparam int NBYTES = DATA_W / 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef enum logic {CLEAR, IDLE} stateT;

  stateT             state;
  stateT             stateNext;
  logic [ADDR_W-1:0] clrCnt;
  logic [ADDR_W-1:0] clrCntNext;
  logic              clrWe;
  logic              readyReg;
  logic              rdPend;
  logic              validReg;
  logic [DATA_W-1:0] rdData;
  logic [DATA_W-1:0] outReg;
  logic              reqAcc;
  logic              wrAcc;
  logic              rdAcc;

  logic [DATA_W-1:0] mem [DEPTH];

  assign reqAcc = bus.en_DM & readyReg;
  assign wrAcc  = reqAcc & bus.we_DM;
  assign rdAcc  = reqAcc & ~bus.we_DM;

  always_comb begin
    stateNext  = state;
    clrCntNext = clrCnt;
    clrWe      = 1'b0;
    case (state)
      CLEAR: begin
        // rst gating keeps the array untouched while reset is held
        clrWe      = ~rst;
        clrCntNext = clrCnt + ADDR_W'(1);
        if (clrCnt == {ADDR_W{1'b1}}) stateNext = IDLE;
      end
      IDLE: begin
        stateNext = IDLE;
      end
      default: stateNext = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if (CLEAR_ON_RESET) state <= CLEAR;
      else                state <= IDLE;
      clrCnt   <= '0;
      readyReg <= 1'b0;
      rdPend   <= 1'b0;
      validReg <= 1'b0;
      outReg   <= '0;
    end else begin
      state    <= stateNext;
      clrCnt   <= clrCntNext;
      readyReg <= (stateNext == IDLE);
      rdPend   <= rdAcc;
      validReg <= rdPend;
      if (rdPend) outReg <= rdData;
    end
  end

  // Array has no reset: only the sweep zeroes it.
  always_ff @(posedge clk) begin
    if (clrWe) begin
      mem[clrCnt] <= '0;
    end else if (wrAcc) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (bus.be_DM[i]) mem[bus.addDM][8*i +: 8] <= bus.dataDM[8*i +: 8];
      end
    end
    if (rdAcc) rdData <= mem[bus.addDM];
  end

  assign bus.outDM    = outReg;
  assign bus.valid_DM = validReg;
  assign bus.ready_DM = readyReg;
endmodule

// File: tb/tb_datamem_bank.sv
// Directed bench for datamem_bank: sweep timing, byte-enable writes, read
// latency, dropped requests and reset behaviour on two parameterisations.
module tb_datamem_bank;
  logic clk = 1'b0;
  logic rst;
  logic rstB;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  datamem_bank_if #(.DATA_W(32), .ADDR_W(12)) busA ();
  datamem_bank_if #(.DATA_W(32), .ADDR_W(4))  busB ();

  datamem_bank #(.DATA_W(32), .ADDR_W(12), .CLEAR_ON_RESET(1'b1)) dutA (
    .clk(clk), .rst(rst), .bus(busA)
  );
  datamem_bank #(.DATA_W(32), .ADDR_W(4), .CLEAR_ON_RESET(1'b0)) dutB (
    .clk(clk), .rst(rstB), .bus(busB)
  );

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [11:0] addr;
    logic [31:0] data;
    logic        expValid;
    logic [31:0] expOut;
    string       name;
  } vecT;

  vecT vecs[12];

  function automatic vecT mkVec(input logic we, input logic [3:0] be, input logic [11:0] addr,
                                input logic [31:0] data, input logic expValid,
                                input logic [31:0] expOut, input string name);
    vecT v;
    v.we = we; v.be = be; v.addr = addr; v.data = data;
    v.expValid = expValid; v.expOut = expOut; v.name = name;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs until ready rises (bounded), optionally firing one write into the sweep.
  task automatic waitReady(input int dropAt, output int n, output logic sawValid);
    n = 0;
    sawValid = 1'b0;
    while (busA.ready_DM !== 1'b1 && n < 5000) begin
      if (n == dropAt) begin
        busA.en_DM = 1'b1; busA.we_DM = 1'b1; busA.be_DM = 4'hF;
        busA.addDM = 12'h002; busA.dataDM = 32'h00001EFE;
      end else begin
        busA.en_DM = 1'b0;
      end
      tick;
      n++;
      if (busA.valid_DM !== 1'b0) sawValid = 1'b1;
    end
    busA.en_DM = 1'b0;
  endtask

  task automatic applyVec(input vecT v);
    busA.en_DM = 1'b1; busA.we_DM = v.we; busA.be_DM = v.be;
    busA.addDM = v.addr; busA.dataDM = v.data;
    tick;
    busA.en_DM = 1'b0;
    check({v.name, "_early"}, {31'b0, busA.valid_DM}, 32'h0);
    tick;
    check({v.name, "_valid"}, {31'b0, busA.valid_DM}, {31'b0, v.expValid});
    check({v.name, "_out"}, busA.outDM, v.expOut);
    tick;
    check({v.name, "_pulse_end"}, {31'b0, busA.valid_DM}, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int   n;
    logic sawValid;

    vecs[0]  = mkVec(1'b0, 4'h0, 12'hFFF, 32'h0,        1'b1, 32'h00000000, "rd_fff_cleared");
    vecs[1]  = mkVec(1'b0, 4'h0, 12'h002, 32'h0,        1'b1, 32'h00000000, "rd_002_dropped");
    vecs[2]  = mkVec(1'b1, 4'hF, 12'h001, 32'h00001DFE, 1'b0, 32'h00000000, "wr_001_full");
    vecs[3]  = mkVec(1'b0, 4'h0, 12'h001, 32'h0,        1'b1, 32'h00001DFE, "rd_001_full");
    vecs[4]  = mkVec(1'b1, 4'h5, 12'h001, 32'hAABBCCDD, 1'b0, 32'h00001DFE, "wr_001_be5");
    vecs[5]  = mkVec(1'b0, 4'h0, 12'h001, 32'h0,        1'b1, 32'h00BB1DDD, "rd_001_be5");
    vecs[6]  = mkVec(1'b1, 4'h0, 12'h002, 32'hFFFFFFFF, 1'b0, 32'h00BB1DDD, "wr_002_be0");
    vecs[7]  = mkVec(1'b0, 4'h0, 12'h002, 32'h0,        1'b1, 32'h00000000, "rd_002_be0");
    vecs[8]  = mkVec(1'b1, 4'hA, 12'h002, 32'h12345678, 1'b0, 32'h00000000, "wr_002_beA");
    vecs[9]  = mkVec(1'b0, 4'h0, 12'h002, 32'h0,        1'b1, 32'h12005600, "rd_002_beA");
    vecs[10] = mkVec(1'b1, 4'hF, 12'hFFF, 32'hDEADBEEF, 1'b0, 32'h12005600, "wr_fff_full");
    vecs[11] = mkVec(1'b0, 4'h0, 12'hFFF, 32'h0,        1'b1, 32'hDEADBEEF, "rd_fff_full");

    rst = 1'b1; rstB = 1'b1;
    busA.en_DM = 1'b0; busA.we_DM = 1'b0; busA.be_DM = '0; busA.dataDM = '0; busA.addDM = '0;
    busB.en_DM = 1'b0; busB.we_DM = 1'b0; busB.be_DM = '0; busB.dataDM = '0; busB.addDM = '0;
    repeat (3) tick;
    check("rstA_out",   busA.outDM, 32'h0);
    check("rstA_valid", {31'b0, busA.valid_DM}, 32'h0);
    check("rstA_ready", {31'b0, busA.ready_DM}, 32'h0);
    check("rstB_ready", {31'b0, busB.ready_DM}, 32'h0);

    rst = 1'b0;
    waitReady(10, n, sawValid);
    check("sweep1_cycles", n, 4096);
    check("sweep1_no_valid", {31'b0, sawValid}, 32'h0);

    foreach (vecs[i]) applyVec(vecs[i]);

    // write then read of the same address on consecutive edges
    busA.en_DM = 1'b1; busA.we_DM = 1'b1; busA.be_DM = 4'hF;
    busA.addDM = 12'h003; busA.dataDM = 32'hCAFEF00D;
    tick;
    busA.we_DM = 1'b0;
    tick;
    busA.en_DM = 1'b0;
    check("wr_rd_early", {31'b0, busA.valid_DM}, 32'h0);
    tick;
    check("wr_rd_valid", {31'b0, busA.valid_DM}, 32'h1);
    check("wr_rd_out", busA.outDM, 32'hCAFEF00D);
    tick;

    // back-to-back reads 0x001, 0x002, 0x001
    busA.en_DM = 1'b1; busA.we_DM = 1'b0; busA.addDM = 12'h001;
    tick;
    check("b2b_early", {31'b0, busA.valid_DM}, 32'h0);
    busA.addDM = 12'h002;
    tick;
    check("b2b_v1", {31'b0, busA.valid_DM}, 32'h1);
    check("b2b_d1", busA.outDM, 32'h00BB1DDD);
    busA.addDM = 12'h001;
    tick;
    check("b2b_v2", {31'b0, busA.valid_DM}, 32'h1);
    check("b2b_d2", busA.outDM, 32'h12005600);
    busA.en_DM = 1'b0;
    tick;
    check("b2b_v3", {31'b0, busA.valid_DM}, 32'h1);
    check("b2b_d3", busA.outDM, 32'h00BB1DDD);
    tick;
    check("b2b_end", {31'b0, busA.valid_DM}, 32'h0);
    check("b2b_hold", busA.outDM, 32'h00BB1DDD);

    // reset lands while a read is in flight
    busA.en_DM = 1'b1; busA.we_DM = 1'b0; busA.addDM = 12'h003;
    tick;
    busA.en_DM = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("pend_rst_out",   busA.outDM, 32'h0);
    check("pend_rst_valid", {31'b0, busA.valid_DM}, 32'h0);
    check("pend_rst_ready", {31'b0, busA.ready_DM}, 32'h0);
    tick;
    check("pend_rst_valid2", {31'b0, busA.valid_DM}, 32'h0);
    rst = 1'b0;

    // abort sweep after 100 cleared words
    repeat (100) tick;
    check("mid_sweep_ready", {31'b0, busA.ready_DM}, 32'h0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ready", {31'b0, busA.ready_DM}, 32'h0);
    check("mid_rst_valid", {31'b0, busA.valid_DM}, 32'h0);
    tick;
    rst = 1'b0;
    waitReady(-1, n, sawValid);
    check("sweep2_cycles", n, 4096);
    applyVec(mkVec(1'b0, 4'h0, 12'h001, 32'h0, 1'b1, 32'h00000000, "rd_001_recleared"));
    applyVec(mkVec(1'b0, 4'h0, 12'hFFF, 32'h0, 1'b1, 32'h00000000, "rd_fff_recleared"));

    // small bank without sweep
    check("B_rst_ready", {31'b0, busB.ready_DM}, 32'h0);
    rstB = 1'b0;
    #1;
    check("B_release_ready", {31'b0, busB.ready_DM}, 32'h0);
    tick;
    check("B_first_edge_ready", {31'b0, busB.ready_DM}, 32'h1);
    busB.en_DM = 1'b1; busB.we_DM = 1'b1; busB.be_DM = 4'hF;
    busB.addDM = 4'hF; busB.dataDM = 32'h0BADF00D;
    tick;
    busB.we_DM = 1'b0;
    tick;
    busB.en_DM = 1'b0;
    tick;
    check("B_rd_valid", {31'b0, busB.valid_DM}, 32'h1);
    check("B_rd_out", busB.outDM, 32'h0BADF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/datamem_bank.md
DATAMEM_BANK -- requirements
Module: datamem_bank

Interface
REQ-001 Parameter DATA_W, default 32: data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 12: address width; memory depth DEPTH = 2**ADDR_W words.
REQ-003 Parameter CLEAR_ON_RESET, default 1: 1 = zero-fill sweep after reset; 0 = no sweep.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 en_DM  input  1  request strobe; a request is accepted on a rising edge when en_DM=1 and ready_DM=1.
REQ-007 we_DM  input  1  1 = write request, 0 = read request; ignored when en_DM=0.
REQ-008 be_DM  input  DATA_W/8  per-byte write enable; bit i qualifies dataDM[8i+7:8i].
REQ-009 dataDM  input  DATA_W  write data.
REQ-010 addDM  input  ADDR_W  word address.
REQ-011 outDM  output  DATA_W  registered read data.
REQ-012 valid_DM  output  1  one-cycle pulse: outDM holds new read data.
REQ-013 ready_DM  output  1  1 = requests accepted; 0 = clear sweep in progress.

Function
REQ-014 Two states, CLEAR and IDLE; on reset exit the FSM SHALL enter CLEAR if CLEAR_ON_RESET=1, otherwise IDLE.
REQ-015 CLEAR: each cycle the block SHALL write 0 to address clr_cnt and increment clr_cnt (ADDR_W bits) from 0 upward.
REQ-016 CLEAR -> IDLE SHALL occur on the edge that writes address DEPTH-1; the sweep takes exactly DEPTH cycles.
REQ-017 ready_DM SHALL be 0 in CLEAR and 1 in IDLE, driven from the state register.
REQ-018 Requests presented while ready_DM=0 SHALL be dropped: no memory change, no valid_DM pulse.
REQ-019 Accepted write: only bytes with be_DM[i]=1 SHALL be updated; all other bytes retain their old value. be_DM=0 is a legal no-op.
REQ-020 Accepted write SHALL NOT pulse valid_DM and SHALL NOT change outDM.
REQ-021 Accepted read at edge N: outDM SHALL carry mem[addDM] and valid_DM SHALL be 1 for the cycle after edge N+1 only. Latency is 1 cycle.
REQ-022 Reads SHALL be accepted every cycle; back-to-back reads give consecutive valid_DM pulses in request order.
REQ-023 A read accepted on the edge after a write to the same address SHALL return the newly written data.
REQ-024 outDM SHALL hold its last read value until the next accepted read.
REQ-025 addDM SHALL use all ADDR_W bits; no out-of-range case exists.

Reset
REQ-026 While rst=1: outDM=0, valid_DM=0, ready_DM=0, clr_cnt=0, state=CLEAR (or IDLE if CLEAR_ON_RESET=0, ready_DM rises on the first edge after release).
REQ-027 Reset SHALL NOT directly clear the memory array; zeroing is done only by the CLEAR sweep.
REQ-028 Reset asserted mid-sweep SHALL abort the sweep; after release the sweep SHALL restart at address 0 and run the full DEPTH cycles.
REQ-029 Reset during a pending read SHALL suppress that read's valid_DM pulse.

Verification
REQ-030 Post-reset sweep (defaults): release rst -> ready_DM=0 for 4096 cycles, then 1; read 0xFFF -> outDM=0x00000000, valid_DM pulses once.
REQ-031 Write/read: write 0x00001DFE to 0x001 with be_DM=4'hF, read 0x001 on the next edge -> outDM=0x00001DFE one cycle later.
REQ-032 Byte enables: over 0x00001DFE at 0x001, write 0xAABBCCDD with be_DM=4'b0101, read back -> outDM=0x00BB1DDD.
REQ-033 Dropped request: write 0x00001EFE to 0x002 ten cycles into the sweep; after ready_DM=1, read 0x002 -> 0x00000000, and no valid_DM pulse during the sweep.
REQ-034 Mid-sweep reset: assert rst at clr_cnt=100 -> outputs go to reset values at once, without a clock edge; after release, ready_DM rises after 4096 more cycles.
REQ-035 Back-to-back reads of 0x001, 0x002, 0x001 -> valid_DM high on 3 consecutive cycles with data in that order; then, with ADDR_W=4 and CLEAR_ON_RESET=0, ready_DM=1 on the first edge after reset.
